// File: rtl/axis_uart_pkg.sv
// axis_uart_pkg: shared state encoding, frame constants and baud divisor helper
// for the sample-to-UART logger.
package axis_uart_pkg;
    localparam int FRAME_BYTES = 3;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
    function automatic int clks_per_bit(input int fclk, input int baud);
        return (fclk + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/axis_sample_uart_tx_if.sv
// axis_sample_uart_tx_if: AXI-Stream sample channel between the filter and the UART logger.
interface axis_sample_uart_tx_if #(parameter int DATA_WIDTH = 16);
    logic [DATA_WIDTH-1:0] tdata;
    logic tvalid;
    logic tready;
    modport master (output tdata, tvalid, input tready);
    modport slave (input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_sample_uart_tx_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers; full/empty/count fall out of the pointer difference.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic full,
    output logic empty,
    output logic [AW:0] count
);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign dout = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + ONE;
        end
    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/axis_sample_uart_tx.sv
// axis_sample_uart_tx: buffers 16-bit samples and sends each as an 8N1 frame
// of SYNC_BYTE, MSB, LSB on tx.
module axis_sample_uart_tx
    import axis_uart_pkg::*;
#(
    parameter int FCLK = 50_000_000,
    parameter int BAUD = 115_200,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    axis_sample_uart_tx_if.slave s_axis,
    output logic tx,
    output logic busy,
    output logic [7:0] overflow_cnt
);
    localparam int CPB = clks_per_bit(FCLK, BAUD);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CPB);
    localparam logic [BW-1:0] ONE = BW'(1);
    localparam logic [BW-1:0] LAST = BW'(CPB - 1);
    localparam logic [BW-1:0] LAST_CHAIN = BW'(CPB - 2);
    localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);
    localparam logic [AW:0] ALMOST = (AW+1)'(FIFO_DEPTH - 1);
    state_t state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [1:0] byte_idx, byte_idx_n;
    logic [DATA_WIDTH-1:0] shadow, shadow_n, fifo_dout;
    logic [7:0] shift, shift_n;
    logic [AW:0] fifo_count;
    logic push, pop, fifo_full, fifo_empty, more;
    assign push = s_axis.tvalid && s_axis.tready;
    assign more = byte_idx != LAST_BYTE || !fifo_empty;
    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(s_axis.tdata),
        .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
    );
    always_comb begin
        state_n = state;
        baud_n = baud + ONE;
        bit_idx_n = bit_idx;
        byte_idx_n = byte_idx;
        shadow_n = shadow;
        shift_n = shift;
        pop = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop = 1'b1;
                shadow_n = fifo_dout;
                byte_idx_n = '0;
                baud_n = '0;
                state_n = LOAD;
            end
            LOAD: begin
                shift_n = byte_idx == 2'd0 ? SYNC_BYTE : byte_idx == 2'd1 ? shadow[15:8] : shadow[7:0];
                baud_n = '0;
                state_n = START;
            end
            START: if (baud == LAST) begin
                baud_n = '0;
                bit_idx_n = '0;
                state_n = DATA;
            end
            DATA: if (baud == LAST) begin
                baud_n = '0;
                bit_idx_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_n = STOP;
            end
            // A chained byte leaves STOP one cycle early so the LOAD cycle completes the stop bit.
            STOP: if (baud == LAST_CHAIN && more) begin
                baud_n = '0;
                state_n = LOAD;
                byte_idx_n = byte_idx == LAST_BYTE ? 2'd0 : byte_idx + 2'd1;
                pop = byte_idx == LAST_BYTE;
                shadow_n = byte_idx == LAST_BYTE ? fifo_dout : shadow;
            end else if (baud == LAST) begin
                baud_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            baud <= '0;
            bit_idx <= '0;
            byte_idx <= '0;
            shadow <= '0;
            shift <= '0;
            tx <= 1'b1;
            busy <= 1'b0;
            s_axis.tready <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            state <= state_n;
            baud <= baud_n;
            bit_idx <= bit_idx_n;
            byte_idx <= byte_idx_n;
            shadow <= shadow_n;
            shift <= shift_n;
            tx <= state == START ? 1'b0 : state == DATA ? shift[bit_idx] : 1'b1;
            busy <= state != IDLE || !fifo_empty;
            s_axis.tready <= pop || !(fifo_full || (push && fifo_count == ALMOST));
            if (s_axis.tvalid && !s_axis.tready && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 8'd1;
        end
endmodule

// File: tb/tb_axis_sample_uart_tx.sv
// tb_axis_sample_uart_tx: directed and random samples, decoded by a UART receiver model
// and compared with the frame format derived from the accepted samples.
module tb_axis_sample_uart_tx;
    localparam int CPB = 4;
    localparam logic [7:0] SYNC = 8'hA5;
    typedef struct {
        logic [7:0] d;
        bit ok;
        int t;
        logic bsy;
    } rx_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic tx, busy;
    logic [7:0] overflow_cnt;
    int ncmp = 0, nfail = 0, cyc = 0, stalls = 0, last_t = 0;
    rx_t rx_q[$];
    logic [15:0] acc_q[$];
    logic [15:0] burst [20];
    axis_sample_uart_tx_if #(.DATA_WIDTH(16)) s_axis ();
    axis_sample_uart_tx #(.FCLK(50_000_000), .BAUD(12_500_000), .DATA_WIDTH(16),
                          .FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(s_axis), .tx(tx), .busy(busy), .overflow_cnt(overflow_cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Reference bookkeeping: accepted samples in order and stalled-cycle count since reset.
    always @(posedge clk) begin
        if (!rst_n) stalls <= 0;
        else if (s_axis.tvalid && !s_axis.tready) stalls <= stalls + 1;
        if (rst_n && s_axis.tvalid && s_axis.tready) acc_q.push_back(s_axis.tdata);
    end
    // UART receiver: each bit must hold its level for exactly CPB samples.
    initial begin : uart_rx
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin : one_byte
                rx_t r;
                r.ok = 1'b1;
                r.t = cyc;
                r.d = '0;
                for (int i = 1; i < CPB; i++) begin @(negedge clk); if (tx !== 1'b0) r.ok = 1'b0; end
                for (int b = 0; b < 8; b++) begin
                    @(negedge clk);
                    r.d[b] = tx;
                    for (int i = 1; i < CPB; i++) begin @(negedge clk); if (tx !== r.d[b]) r.ok = 1'b0; end
                end
                for (int i = 0; i < CPB; i++) begin @(negedge clk); if (tx !== 1'b1) r.ok = 1'b0; end
                r.bsy = busy;
                rx_q.push_back(r);
            end
        end
    end
    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", ncmp);
        $fatal(1, "watchdog expired");
    end
    function automatic int sat(input int v);
        return v > 255 ? 255 : v;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic send(input logic [15:0] d);
        int n0 = acc_q.size();
        int w = 0;
        s_axis.tdata = d;
        s_axis.tvalid = 1'b1;
        while (acc_q.size() == n0 && w < 2000) begin tick(1); w++; end
        s_axis.tvalid = 1'b0;
        chk("accept", 32'(acc_q.size()), 32'(n0 + 1));
    endtask
    task automatic wait_rx(input int n, input int budget);
        int w = 0;
        while (rx_q.size() < n && w < budget) begin tick(1); w++; end
        chk("rx byte count", 32'(rx_q.size()), 32'(n));
    endtask
    task automatic take_byte(input string tag, input logic [7:0] e, input bit chained);
        rx_t r;
        if (rx_q.size() == 0) begin
            chk({tag, " missing"}, 32'(rx_q.size()), 32'd1);
            return;
        end
        r = rx_q.pop_front();
        chk({tag, " data"}, 32'(r.d), 32'(e));
        chk({tag, " bit timing"}, 32'(r.ok), 32'd1);
        if (chained) chk({tag, " spacing"}, 32'(r.t - last_t), 32'(10 * CPB));
        last_t = r.t;
    endtask
    task automatic take_frame(input string tag, input logic [15:0] s, input bit chained);
        take_byte({tag, " sync"}, SYNC, chained);
        take_byte({tag, " msb"}, s[15:8], 1'b1);
        take_byte({tag, " lsb"}, s[7:0], 1'b1);
    endtask
    task automatic reset_pulse();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick(12 * CPB);
        rx_q.delete();
        acc_q.delete();
    endtask
    initial begin : main
        int k, first_low, w;
        bit resumed;
        rx_t r;
        s_axis.tvalid = 1'b0;
        s_axis.tdata = '0;
        #2 rst_n = 1'b0;
        tick(2);
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset tready", 32'(s_axis.tready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ovf", 32'(overflow_cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("tready before edge", 32'(s_axis.tready), 32'd0);
        tick(1);
        chk("tready after release", 32'(s_axis.tready), 32'd1);
        tick(3);
        // single sample, FIFO empty
        send(16'h1234);
        k = 0;
        do begin tick(1); k++; end while (tx !== 1'b0 && k < 20);
        chk("start latency", 32'(k), 32'd3);
        wait_rx(3, 40 * CPB);
        if (rx_q.size() >= 3) begin
            r = rx_q[2];
            chk("busy at last stop", 32'(r.bsy), 32'd1);
        end
        chk("busy after frame", 32'(busy), 32'd0);
        take_byte("h1234 sync", 8'hA5, 1'b0);
        take_byte("h1234 msb", 8'h12, 1'b1);
        take_byte("h1234 lsb", 8'h34, 1'b1);
        // negative sample keeps its sign bits
        tick(5);
        send(16'h8001);
        wait_rx(3, 40 * CPB);
        take_byte("h8001 sync", 8'hA5, 1'b0);
        take_byte("h8001 msb", 8'h80, 1'b1);
        take_byte("h8001 lsb", 8'h01, 1'b1);
        // burst of 20 with tvalid held high
        tick(5);
        acc_q.delete();
        foreach (burst[i]) burst[i] = 16'($urandom);
        first_low = -1;
        resumed = 1'b0;
        w = 0;
        s_axis.tvalid = 1'b1;
        while (acc_q.size() < 20 && w < 5000) begin
            s_axis.tdata = burst[acc_q.size()];
            tick(1);
            w++;
            if (first_low < 0 && !s_axis.tready) first_low = acc_q.size();
            else if (first_low >= 0 && !resumed && s_axis.tready) begin
                resumed = 1'b1;
                chk("ovf at resume", 32'(overflow_cnt), 32'(sat(stalls)));
            end
        end
        s_axis.tvalid = 1'b0;
        chk("burst accepted", 32'(acc_q.size()), 32'd20);
        chk("tready low after", 32'(first_low), 32'd17);
        wait_rx(60, 70 * 10 * CPB);
        for (int i = 0; i < 20; i++) take_frame($sformatf("burst%0d", i), burst[i], i > 0);
        chk("burst ovf", 32'(overflow_cnt), 32'(sat(stalls)));
        // reset during data bits of the LSB byte (all zeros, so tx is low)
        tick(5);
        send(16'h1200);
        wait_rx(2, 40 * CPB);
        tick(CPB + 2);
        chk("tx low pre-reset", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1 chk("tx async reset", 32'(tx), 32'd1);
        chk("tready in reset", 32'(s_axis.tready), 32'd0);
        chk("busy in reset", 32'(busy), 32'd0);
        chk("ovf in reset", 32'(overflow_cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick(1);
        chk("tready after mid reset", 32'(s_axis.tready), 32'd1);
        chk("fifo empty after reset", 32'(busy), 32'd0);
        tick(12 * CPB);
        rx_q.delete();
        acc_q.delete();
        send(16'h00FF);
        wait_rx(3, 40 * CPB);
        take_frame("h00FF", 16'h00FF, 1'b0);
        // saturation with FIFO full
        tick(5);
        s_axis.tvalid = 1'b1;
        w = 0;
        while (s_axis.tready && w < 100) begin s_axis.tdata = 16'($urandom); tick(1); w++; end
        tick(300);
        s_axis.tvalid = 1'b0;
        chk("ovf saturated model", 32'(overflow_cnt), 32'(sat(stalls)));
        chk("ovf saturated", 32'(overflow_cnt), 32'd255);
        reset_pulse();
        // sparse random samples against the scoreboard
        for (int i = 0; i < 150; i++) begin
            tick($urandom_range(100, 300));
            send(16'($urandom));
        end
        wait_rx(acc_q.size() * 3, 60 * CPB);
        foreach (acc_q[i]) take_frame($sformatf("rand%0d", i), acc_q[i], 1'b0);
        chk("random ovf", 32'(overflow_cnt), 32'd0);
        chk("random ovf model", 32'(overflow_cnt), 32'(sat(stalls)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
